uart_tx_arbiter: RTL

- Shares one uart transmitter among NUM_REQ byte producers (debug console, trace, firmware mailbox, ...).
- Round-robin arbitrates single-byte requests and acts as an APB master on the uart register port.
- For each byte it polls the status register until tx_ready, then writes the TX data register.
- Sits between the requesters and the uart APB slave port, on the same PCLK.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// APB link between the transmit arbiter (master) and the uart register port (slave).
// Address is 5 bits and data is 8 bits, matching the uart register map.
interface uart_tx_arbiter_if;
  logic [4:0] m_PADDR;
  logic       m_PSEL;
  logic       m_PENABLE;
  logic       m_PWRITE;
  logic [7:0] m_PWDATA;
  logic [7:0] m_PRDATA;
  logic       m_PREADY;
  logic       m_PSLVERR;

  modport master (
    output m_PADDR, m_PSEL, m_PENABLE, m_PWRITE, m_PWDATA,
    input  m_PRDATA, m_PREADY, m_PSLVERR
  );

  modport slave (
    input  m_PADDR, m_PSEL, m_PENABLE, m_PWRITE, m_PWDATA,
    output m_PRDATA, m_PREADY, m_PSLVERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NUM_REQ byte producers.
// Each granted byte: poll the status register until tx_ready, then write TX data.
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter logic [4:0] STATUS_ADDR  = 5'h04,
  parameter logic [4:0] TX_DATA_ADDR = 5'h00,
  parameter int         TX_READY_BIT = 0,
  parameter int         POLL_MAX     = 1024
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  uart_tx_arbiter_if.master          apb,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_pulse,
  output logic                       timeout_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, P_SETUP, P_ACCESS, W_SETUP, W_ACCESS} state_e;

  state_e          state, state_n;
  logic [PW-1:0]   poll_cnt, poll_n;
  logic [GW-1:0]   last, last_n, grant_n, pick;
  logic [7:0]      byte_q, byte_n;
  logic [NUM_REQ-1:0] ack_n;
  logic [4:0]      paddr_q, paddr_n;
  logic [7:0]      pwdata_q, pwdata_n;
  logic            psel_q, penable_q, pwrite_q;
  logic            psel_n, penable_n, pwrite_n;
  logic            err_n, tmo_n, busy_n, found;
  int              cand;

  // Only the tx_ready bit of the status word matters.
  logic unused_prdata;
  assign unused_prdata = ^apb.m_PRDATA;

  assign apb.m_PADDR   = paddr_q;
  assign apb.m_PWDATA  = pwdata_q;
  assign apb.m_PSEL    = psel_q;
  assign apb.m_PENABLE = penable_q;
  assign apb.m_PWRITE  = pwrite_q;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = GW'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_n  = state;
    poll_n   = poll_cnt;
    last_n   = last;
    grant_n  = grant_id;
    byte_n   = byte_q;
    ack_n    = '0;
    err_n    = 1'b0;
    tmo_n    = 1'b0;
    paddr_n  = paddr_q;
    pwdata_n = pwdata_q;

    case (state)
      IDLE: begin
        if (found) begin
          state_n     = P_SETUP;
          last_n      = pick;
          grant_n     = pick;
          byte_n      = req_data[8*pick +: 8];
          poll_n      = '0;
          ack_n[pick] = 1'b1;
        end
      end
      P_SETUP: state_n = P_ACCESS;
      P_ACCESS: begin
        if (apb.m_PREADY) begin
          if (apb.m_PSLVERR) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (apb.m_PRDATA[TX_READY_BIT]) begin
            state_n = W_SETUP;
          end else if (poll_cnt + PW'(1) == PW'(POLL_MAX)) begin
            tmo_n   = 1'b1;
            state_n = IDLE;
          end else begin
            poll_n  = poll_cnt + PW'(1);
            state_n = P_SETUP;
          end
        end
      end
      W_SETUP: state_n = W_ACCESS;
      W_ACCESS: begin
        if (apb.m_PREADY) begin
          err_n   = apb.m_PSLVERR;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next state.
    psel_n    = (state_n != IDLE);
    penable_n = (state_n == P_ACCESS) || (state_n == W_ACCESS);
    pwrite_n  = (state_n == W_SETUP) || (state_n == W_ACCESS);
    busy_n    = (state_n != IDLE);
    if (state_n == P_SETUP) paddr_n = STATUS_ADDR;
    if (state_n == W_SETUP) begin
      paddr_n  = TX_DATA_ADDR;
      pwdata_n = byte_n;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      last          <= GW'(NUM_REQ - 1);
      grant_id      <= '0;
      byte_q        <= '0;
      req_ack       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      busy          <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state         <= state_n;
      poll_cnt      <= poll_n;
      last          <= last_n;
      grant_id      <= grant_n;
      byte_q        <= byte_n;
      req_ack       <= ack_n;
      paddr_q       <= paddr_n;
      pwdata_q      <= pwdata_n;
      psel_q        <= psel_n;
      penable_q     <= penable_n;
      pwrite_q      <= pwrite_n;
      busy          <= busy_n;
      err_pulse     <= err_n;
      timeout_pulse <= tmo_n;
    end
  end

endmodule
